// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared types and constants for the serial pattern detector
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0010_1001;
    localparam int         SEQ_DEF_LEN     = 6;

    function automatic int seq_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_matcher.sv
// rtl/seq_matcher.sv - bit history, length-masked compare and registered match
module seq_matcher
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          shift_en,
    input  logic                          bit_in,
    input  logic [PAT_W-1:0]              pattern,
    input  logic [seq_len_w(PAT_W)-1:0]   len,
    output logic                          hit,
    output logic                          match
);

    localparam int LEN_W = seq_len_w(PAT_W);

    logic [PAT_W-1:0] history_q, history_d, history_sh;
    logic [LEN_W-1:0] bits_seen_q, bits_seen_d, bits_seen_sh;
    logic             match_q, match_d;
    logic [LEN_W-1:0] len_eff;
    logic [PAT_W-1:0] len_mask;

    always_comb begin
        len_eff  = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_eff));
        end
        history_sh   = {history_q[PAT_W-2:0], bit_in};
        bits_seen_sh = (bits_seen_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W)
                                                      : bits_seen_q + LEN_W'(1);
        // hit looks at the history as it will be after this bit lands
        hit = shift_en && (len_eff != '0) && (bits_seen_sh >= len_eff)
              && (((history_sh ^ pattern) & len_mask) == '0);

        history_d   = history_q;
        bits_seen_d = bits_seen_q;
        match_d     = hit;
        if (clear) begin
            history_d   = '0;
            bits_seen_d = '0;
            match_d     = 1'b0;
        end else if (shift_en) begin
            history_d   = history_sh;
            bits_seen_d = bits_seen_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history_q   <= '0;
            bits_seen_q <= '0;
            match_q     <= 1'b0;
        end else begin
            history_q   <= history_d;
            bits_seen_q <= bits_seen_d;
            match_q     <= match_d;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - byte serializer, control FSM, config and match counter
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(SEQ_DEF_PATTERN),
    parameter int               DEF_LEN     = SEQ_DEF_LEN
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [PAT_W-1:0]            cfg_pattern,
    input  logic [seq_len_w(PAT_W)-1:0] cfg_len,
    input  logic [CNT_W-1:0]            cfg_limit,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_data,
    output logic                        tone,
    output logic [CNT_W-1:0]            match_count,
    output logic                        busy,
    output logic                        done
);

    localparam int LEN_W = seq_len_w(PAT_W);

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             shift_en, matcher_clear, hit;

    assign shift_en      = (state_q == SHIFT) && !stop;
    assign matcher_clear = (stop && (state_q != IDLE))
                         || (start && !stop && ((state_q == IDLE) || (state_q == DONE)));

    seq_matcher #(.PAT_W(PAT_W)) u_matcher (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (matcher_clear),
        .shift_en (shift_en),
        .bit_in   (shreg_q[7]),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit      (hit),
        .match    (tone)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        limit_d   = limit_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    limit_d   = cfg_limit;
                end
                if (start && !stop) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    shreg_d   = in_data;
                    bit_idx_d = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (hit) count_d = count_inc;
                    // reaching the limit abandons the rest of the byte
                    if (hit && (limit_q != '0) && (count_inc == limit_q)) begin
                        state_d = DONE;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = ARMED;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = ARMED;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            limit_q   <= '0;
            count_q   <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign in_ready    = (state_q == ARMED);
    assign busy        = (state_q == ARMED) || (state_q == SHIFT);
    assign done        = (state_q == DONE);
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;
    import seq_ctrl_pkg::*;

    localparam int LEN_W = seq_len_w(8);

    logic             clk = 1'b0;
    logic             rst_n, cfg_we, start, stop, in_valid;
    logic [7:0]       cfg_pattern, cfg_limit, in_data;
    logic [LEN_W-1:0] cfg_len;
    logic             in_ready, tone, busy, done;
    logic [7:0]       match_count;
    logic             s_in_ready, s_tone, s_busy, s_done;
    logic [1:0]       s_count;
    logic [7:0]       m, sm;
    logic             seen;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_limit(cfg_limit), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .tone(tone),
        .match_count(match_count), .busy(busy), .done(done)
    );

    seq_detect_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_limit(cfg_limit[1:0]), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .tone(s_tone),
        .match_count(s_count), .busy(s_busy), .done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic configure(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic [7:0] lim);
        cfg_pattern = p; cfg_len = l; cfg_limit = lim;
        cfg_we = 1'b1; tick(); cfg_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic [7:0] tm, output logic [7:0] stm);
        in_valid = 1'b1; in_data = d; tick(); in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tm[i]  = tone;
            stm[i] = s_tone;
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        cfg_pattern = 8'h00; cfg_len = '0; cfg_limit = 8'h00; in_data = 8'h00;
        tick(); tick();
        check("rst_tone", 8'(tone), 8'd0);
        check("rst_count", match_count, 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd0);
        rst_n = 1'b1; tick();

        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("start_stop_busy", 8'(busy), 8'd0);

        pulse_start();
        check("armed_in_ready", 8'(in_ready), 8'd1);
        check("armed_busy", 8'(busy), 8'd1);
        send_byte(8'h29, m, sm);
        check("def_29_tones", m, 8'h80);
        check("def_29_count", match_count, 8'd1);
        check("def_29_ready", 8'(in_ready), 8'd1);

        pulse_stop(); pulse_start();
        check("restart_count", match_count, 8'd0);
        send_byte(8'h0A, m, sm);
        check("cross_0a_tones", m, 8'h00);
        send_byte(8'h40, m, sm);
        check("cross_40_tones", m, 8'h02);
        check("cross_count", match_count, 8'd1);

        pulse_stop(); configure(8'h05, 4'd3, 8'd0); pulse_start();
        send_byte(8'hAA, m, sm);
        check("p101_tones", m, 8'h54);
        check("p101_count", match_count, 8'd3);

        pulse_stop(); configure(8'h05, 4'd3, 8'd2); pulse_start();
        send_byte(8'hAA, m, sm);
        check("limit_tones", m, 8'h14);
        check("limit_done", 8'(done), 8'd1);
        check("limit_in_ready", 8'(in_ready), 8'd0);
        check("limit_busy", 8'(busy), 8'd0);
        check("limit_count", match_count, 8'd2);
        pulse_start();
        check("rearm_busy", 8'(busy), 8'd1);
        check("rearm_done", 8'(done), 8'd0);
        check("rearm_count", match_count, 8'd0);

        pulse_stop(); configure(8'h05, 4'd3, 8'd0); pulse_start();
        in_valid = 1'b1; in_data = 8'hAA; tick(); in_valid = 1'b0;
        tick(); tick(); tick();
        check("bit3_tone", 8'(tone), 8'd1);
        check("bit3_count", match_count, 8'd1);
        pulse_stop();
        check("stop_busy", 8'(busy), 8'd0);
        check("stop_in_ready", 8'(in_ready), 8'd0);
        seen = tone;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | tone;
        end
        check("stop_no_tone", 8'(seen), 8'd0);
        check("stop_count_kept", match_count, 8'd1);

        configure(8'h29, 4'd6, 8'd0); pulse_start();
        configure(8'h05, 4'd3, 8'd0);
        check("cfg_armed_ready", 8'(in_ready), 8'd1);
        send_byte(8'h29, m, sm);
        check("cfg_gated_tones", m, 8'h80);
        check("cfg_gated_count", match_count, 8'd1);

        pulse_stop(); configure(8'h01, 4'd1, 8'd0); pulse_start();
        send_byte(8'hFF, m, sm);
        check("ones_tones", m, 8'hFF);
        check("ones_count", match_count, 8'd8);
        check("sat_tones", sm, 8'hFF);
        check("sat_count", 8'(s_count), 8'd3);

        in_valid = 1'b1; in_data = 8'h29; tick(); in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_count", match_count, 8'd0);
        check("midrst_busy", 8'(busy), 8'd0);
        pulse_start();
        send_byte(8'h29, m, sm);
        check("midrst_def_tones", m, 8'h80);
        check("midrst_def_count", match_count, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It accepts bytes from an upstream requester over a valid/ready handshake and serializes them MSB-first, one bit per cycle, into an internal matcher. The matcher holds a configurable pattern of up to PAT_W bits; the default pattern is 101001, the team's tone sequence. The controller arms, counts and stops detection, and emits a one-cycle tone pulse per match.

Parameters:
PAT_W, 8, maximum pattern length in bits
CNT_W, 8, width of match counter and match limit
DEF_PATTERN, 8'b0010_1001, pattern loaded at reset; LSB is the last bit of the sequence
DEF_LEN, 6, pattern length loaded at reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  config write strobe; honoured only in IDLE
cfg_pattern  in  PAT_W  pattern bits; bit 0 is the most recent stream bit
cfg_len  in  $clog2(PAT_W+1)  active pattern length
cfg_limit  in  CNT_W  match limit; 0 means unlimited
start  in  1  arm pulse
stop  in  1  abort pulse
in_valid  in  1  byte offered
in_ready  out  1  byte accepted when in_valid and in_ready are both high
in_data  in  8  byte, serialized MSB first
tone  out  1  one-cycle pulse per match
match_count  out  CNT_W  matches since last start; saturating
busy  out  1  state is ARMED or SHIFT
done  out  1  state is DONE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; tone=0, match_count=0, busy=0, done=0, in_ready=0.
  - Pattern and length registers load DEF_PATTERN/DEF_LEN; limit register loads 0.
  - History and bits_seen clear.
- States: IDLE, ARMED, SHIFT, DONE.
- IDLE:
  - cfg_we latches cfg_pattern, cfg_len and cfg_limit; cfg_we in any other state is ignored.
  - start moves to ARMED next cycle.
- start (accepted in IDLE or DONE; ignored in ARMED and SHIFT):
  - clears match_count, history and bits_seen; moves to ARMED.
  - start and stop in the same cycle: stop wins.
- ARMED:
  - in_ready=1 (registered-state decode; no combinational path from in_valid).
  - On handshake: load shift register, bit_idx=0, go to SHIFT.
- SHIFT:
  - in_ready=0; one bit per cycle, MSB first, for bit_idx 0..7.
  - After bit 7: return to ARMED. Throughput is 1 byte per 9 cycles.
- Matcher:
  - Each shifted bit: history = {history[PAT_W-2:0], bit}; bits_seen saturates at PAT_W.
  - match = (bits_seen_next >= len) and (history_next[len-1:0] == pattern[len-1:0]).
  - Overlapping matches are allowed; history persists across bytes.
  - len=0: never matches. len>PAT_W: clamped to PAT_W.
- Match latency:
  - tone is registered and high in the cycle after the matching bit's shift cycle.
  - Byte accepted at edge t gives bits at cycles t+1..t+8; a match on bit k gives tone at cycle t+2+k.
- Counting:
  - match_count increments with tone and saturates at 2^CNT_W-1.
  - tone still pulses while the count is saturated.
- Limit (cfg_limit != 0):
  - When an increment makes match_count == limit, go to DONE after that bit; the remaining bits of the byte are discarded.
  - DONE: in_ready=0, done=1, count held until start, stop or reset.
- stop in ARMED, SHIFT or DONE:
  - IDLE next cycle; in-flight byte discarded; history and bits_seen cleared; match_count retained.
  - Any tone already registered for the final bit still emits.
- Reset mid-operation: same as reset from any state; the current byte is lost.

Decomposition:
- Package seq_ctrl_pkg:
  - state enum (IDLE, ARMED, SHIFT, DONE);
  - DEF_PATTERN and DEF_LEN constants;
  - LEN_W = $clog2(PAT_W+1) localparam function.
- Sub-module seq_matcher: history shift register, bits_seen, length mask/compare, clear input, registered match output.
- seq_detect_ctrl holds the FSM, serializer, config registers and counter.

Test Plan:
- Default config, start, send 0x29 (0010_1001) -> exactly one tone on the cycle after bit 7; match_count=1; in_ready high again.
- Default config, send 0x0A then 0x40 -> cross-byte match; tone after bit 1 of the second byte; match_count=1.
- cfg pattern 3'b101, len 3, limit 0; send 0xAA -> tones after bits 2, 4 and 6; match_count=3.
- Same config with limit 2, send 0xAA:
  - two tones, then DONE after bit 4; done=1, in_ready=0, match_count=2;
  - start then returns to ARMED with match_count=0.
- Stop and config gating:
  - stop asserted during bit 3 -> IDLE next cycle, no further tone, match_count retained;
  - cfg_we while ARMED -> pattern unchanged (verify with a follow-up 0x29 -> match).
- Saturation with CNT_W=2, pattern 1'b1, len 1; send 0xFF -> 8 tones; match_count saturates at 3.
